// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding bytes from NUM_REQ producers into one UART slot.
// Optional packet lock (keep grant until req_last) is enabled by defining UART_TX_SCHED_PKT_LOCK_EN.
module uart_tx_scheduler #(
  parameter int          NUM_REQ   = 4,
  parameter logic [15:0] CTRL_INIT = 16'h8035
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cfg_load,
  input  logic [15:0]          cfg_ctrl,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 slot_cs,
  output logic                 slot_read,
  output logic                 slot_write,
  output logic [4:0]           slot_addr,
  output logic [31:0]          slot_wr_data,
  input  logic [31:0]          slot_rd_data
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_POLL  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CFG   = 3'd5;
  logic [2:0] state_q, state_d;
  logic [PW-1:0] gidx_q, gidx_d, rr_q, rr_d, sel, idx;
  logic cfg_pend_q, cfg_pend_d;
  logic [15:0] cfg_q, cfg_d;
  logic [NUM_REQ-1:0] g_oh;
  logic [7:0] g_byte;
  logic poll_ok, wr_done, ctrl_wr;
`ifdef UART_TX_SCHED_PKT_LOCK_EN
  // An unlocked owner holds req_valid anyway, so requiring it in POLL only matters mid-packet.
  assign poll_ok = ~slot_rd_data[4] & req_valid[gidx_q];
  assign wr_done = req_last[gidx_q];
  logic unused_rd;
  assign unused_rd = ^{slot_rd_data[31:5], slot_rd_data[3:0]};
`else
  assign poll_ok = ~slot_rd_data[4];
  assign wr_done = 1'b1;
  logic unused_rd;
  assign unused_rd = ^{req_last, slot_rd_data[31:5], slot_rd_data[3:0]};
`endif
  // Descending scan so the closest valid index at or after rr_q wins.
  always_comb begin
    sel = rr_q;
    idx = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[idx]) sel = idx;
    end
  end
  always_comb begin
    state_d = (state_q == S_RST)   ? S_INIT :
              (state_q == S_IDLE)  ? (cfg_pend_q ? S_CFG : (|req_valid) ? S_POLL : S_IDLE) :
              (state_q == S_POLL)  ? (poll_ok ? S_WRITE : S_POLL) :
              (state_q == S_WRITE) ? (wr_done ? S_IDLE : S_POLL) : S_IDLE;
    gidx_d = (state_q == S_IDLE && !cfg_pend_q && (|req_valid)) ? sel : gidx_q;
    rr_d = (state_q == S_WRITE && wr_done) ?
           ((int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + PW'(1)) : rr_q;
    cfg_pend_d = cfg_load | (cfg_pend_q & (state_q != S_CFG));
    cfg_d = cfg_load ? cfg_ctrl : cfg_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RST;
      gidx_q     <= '0;
      rr_q       <= '0;
      cfg_pend_q <= 1'b0;
      cfg_q      <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_q      <= cfg_d;
    end
  end
  assign g_oh = NUM_REQ'(1) << gidx_q;
  assign g_byte = req_data[{gidx_q, 3'b000} +: 8];
  assign ctrl_wr = (state_q == S_INIT) || (state_q == S_CFG);
  assign busy = state_q != S_IDLE;
  assign grant = (state_q == S_POLL || state_q == S_WRITE) ? g_oh : '0;
  assign req_ready = (state_q == S_WRITE) ? g_oh : '0;
  assign slot_cs = ctrl_wr || state_q == S_POLL || state_q == S_WRITE;
  assign slot_read = state_q == S_POLL;
  assign slot_write = ctrl_wr || state_q == S_WRITE;
  assign slot_addr = (state_q == S_POLL) ? 5'd1 : (state_q == S_WRITE) ? 5'd3 : 5'd0;
  assign slot_wr_data = (state_q == S_INIT)  ? {16'h0, CTRL_INIT} :
                        (state_q == S_CFG)   ? {16'h0, cfg_q} :
                        (state_q == S_WRITE) ? {24'h0, g_byte} : '0;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: cycle vectors for reset/single byte/full FIFO/cfg, plus sequences
// for mid-operation reset, round-robin order, cfg last-wins and (when enabled) packet lock.
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_last = '1;
  logic [3:0] req_ready, grant;
  logic cfg_load = 1'b0;
  logic [15:0] cfg_ctrl = '0;
  logic busy, slot_cs, slot_read, slot_write;
  logic [4:0] slot_addr;
  logic [31:0] slot_wr_data;
  logic [31:0] slot_rd_data = '0;
  int errors = 0;
  int checks = 0;

  uart_tx_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .cfg_load(cfg_load), .cfg_ctrl(cfg_ctrl),
    .grant(grant), .busy(busy), .slot_cs(slot_cs), .slot_read(slot_read),
    .slot_write(slot_write), .slot_addr(slot_addr), .slot_wr_data(slot_wr_data),
    .slot_rd_data(slot_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [3:0] v; logic [31:0] d; logic full; logic cl; logic [15:0] cc;
    logic busy; logic [3:0] g; logic [3:0] rdy; logic [39:0] sl;
  } vec_t;

  vec_t tv[$];
  localparam logic [39:0] SQ = 40'h0;
  localparam logic [39:0] SP = {3'b110, 5'd1, 32'd0};

  function automatic logic [39:0] sw(input logic [4:0] a, input logic [31:0] d);
    return {3'b101, a, d};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [31:0] d,
                              input logic full, input logic cl, input logic [15:0] cc,
                              input logic b, input logic [3:0] g, input logic [3:0] rdy,
                              input logic [39:0] sl);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.full = full; t.cl = cl; t.cc = cc;
    t.busy = b; t.g = g; t.rdy = rdy; t.sl = sl;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [48:0] outs();
    return {busy, grant, req_ready, slot_cs, slot_read, slot_write, slot_addr, slot_wr_data};
  endfunction

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  initial begin
    int n, last_c;
    logic [31:0] wd [4];
    logic [4:0] wa [4];
    // reset, idle, single byte, full FIFO, cfg during transfer
    tv.push_back(mk(1, 4'h0, 32'h0,      0, 0, 16'h0,    1, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h0, 32'h0,      0, 0, 16'h0,    1, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h0, 32'h0,      0, 0, 16'h0,    1, 4'h0, 4'h0, sw(5'd0, 32'h8035)));
    tv.push_back(mk(0, 4'h0, 32'h0,      0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h4, 32'h410000, 0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h4, 32'h410000, 0, 0, 16'h0,    1, 4'h4, 4'h0, SP));
    tv.push_back(mk(0, 4'h4, 32'h410000, 0, 0, 16'h0,    1, 4'h4, 4'h4, sw(5'd3, 32'h41)));
    tv.push_back(mk(0, 4'h0, 32'h0,      0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h1, 32'h55,     1, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    for (int i = 0; i < 10; i++)
      tv.push_back(mk(0, 4'h1, 32'h55,   1, 0, 16'h0,    1, 4'h1, 4'h0, SP));
    tv.push_back(mk(0, 4'h1, 32'h55,     0, 0, 16'h0,    1, 4'h1, 4'h0, SP));
    tv.push_back(mk(0, 4'h1, 32'h55,     0, 0, 16'h0,    1, 4'h1, 4'h1, sw(5'd3, 32'h55)));
    tv.push_back(mk(0, 4'h2, 32'h6600,   0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h2, 32'h6600,   0, 1, 16'h0a1b, 1, 4'h2, 4'h0, SP));
    tv.push_back(mk(0, 4'h2, 32'h6600,   0, 0, 16'h0,    1, 4'h2, 4'h2, sw(5'd3, 32'h66)));
    tv.push_back(mk(0, 4'h1, 32'h77,     0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h1, 32'h77,     0, 0, 16'h0,    1, 4'h0, 4'h0, sw(5'd0, 32'h0a1b)));
    tv.push_back(mk(0, 4'h1, 32'h77,     0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    tv.push_back(mk(0, 4'h1, 32'h77,     0, 0, 16'h0,    1, 4'h1, 4'h0, SP));
    tv.push_back(mk(0, 4'h1, 32'h77,     0, 0, 16'h0,    1, 4'h1, 4'h1, sw(5'd3, 32'h77)));
    tv.push_back(mk(0, 4'h0, 32'h0,      0, 0, 16'h0,    0, 4'h0, 4'h0, SQ));
    for (int i = 0; i < tv.size(); i++) begin
      if (i > 0) @(negedge clk);
      reset = tv[i].rst; req_valid = tv[i].v; req_data = tv[i].d;
      slot_rd_data = {27'h0, tv[i].full, 4'h0}; cfg_load = tv[i].cl; cfg_ctrl = tv[i].cc;
      #1;
      chk($sformatf("vec%0d", i), {15'h0, outs()}, {15'h0, tv[i].busy, tv[i].g, tv[i].rdy, tv[i].sl});
    end

    // reset in POLL drops the byte and re-runs INIT
    @(negedge clk); req_valid = 4'h4; req_data = 32'h990000; slot_rd_data = 32'h10;
    @(negedge clk);
    @(negedge clk); #1 chk("mid_poll_grant", {60'h0, grant}, 64'h4);
    @(negedge clk); reset = 1'b1; req_valid = '0; #1 chk("mid_rst_state", {15'h0, outs()}, {15'h0, 1'b1, 48'h0});
    @(negedge clk); reset = 1'b0; slot_rd_data = '0; #1 chk("mid_rst_hold", {15'h0, outs()}, {15'h0, 1'b1, 48'h0});
    @(negedge clk); #1 chk("mid_rst_init", {15'h0, outs()}, {15'h0, 1'b1, 8'h0, sw(5'd0, 32'h8035)});
    @(negedge clk); #1 chk("mid_rst_idle", {15'h0, outs()}, 64'h0);

    // round-robin with all requesters valid, rr_ptr freshly reset
    @(negedge clk); req_valid = 4'hF; req_data = 32'h13121110;
    n = 0; last_c = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (slot_write && slot_addr == 5'd3) begin
        chk($sformatf("rr_data%0d", n), {32'h0, slot_wr_data}, {56'h0, 8'h10 + 8'(n % 4)});
        chk($sformatf("rr_ready%0d", n), {60'h0, req_ready}, {60'h0, 4'(1 << (n % 4))});
        if (n > 0) chk($sformatf("rr_gap%0d", n), 64'(c - last_c), 64'd3);
        last_c = c;
        n++;
      end
    end
    if (n < 8) fail_timeout("rr_writes");
    @(negedge clk); req_valid = '0;
    @(negedge clk);

    // two cfg_load pulses during a full-FIFO stall: byte first, then the later value
    req_valid = 4'h4; req_data = 32'hAB0000; slot_rd_data = 32'h10;
    @(negedge clk);
    @(negedge clk); cfg_load = 1'b1; cfg_ctrl = 16'h1111;
    @(negedge clk); cfg_ctrl = 16'h2222;
    @(negedge clk); cfg_load = 1'b0; slot_rd_data = '0;
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      if (n == 1) req_valid = '0;
      #1;
      if (slot_write) begin
        wa[n] = slot_addr; wd[n] = slot_wr_data; n++;
      end
    end
    if (n < 2) fail_timeout("cfg_writes");
    else begin
      chk("cfg_first", {27'h0, wa[0], wd[0]}, {27'h0, 5'd3, 32'hAB});
      chk("cfg_second", {27'h0, wa[1], wd[1]}, {27'h0, 5'd0, 32'h2222});
    end
    @(negedge clk); req_valid = '0;
    @(negedge clk);

`ifdef UART_TX_SCHED_PKT_LOCK_EN
    // move rr_ptr to 1 with one byte from requester 0
    req_valid = 4'h1; req_data = 32'h5A;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge clk); #1;
      if (req_ready[0]) n = 1;
    end
    if (n == 0) fail_timeout("pkt_pre");
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    begin
      logic [7:0] exp_b [4];
      int k;
      logic adv;
      exp_b[0] = 8'hB1; exp_b[1] = 8'hB2; exp_b[2] = 8'hB3; exp_b[3] = 8'h5B;
      k = 0; adv = 1'b0; n = 0; last_c = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
        @(negedge clk);
        if (adv) begin k++; adv = 1'b0; end
        req_valid = {2'b00, k < 3, 1'b1};
        req_data = {16'h0, 8'hB1 + 8'(k), 8'h5B};
        req_last = {2'b11, k == 2, 1'b1};
        #1;
        if (slot_write && slot_addr == 5'd3) begin
          chk($sformatf("pkt_data%0d", n), {32'h0, slot_wr_data}, {56'h0, exp_b[n]});
          if (n == 1 || n == 2) chk($sformatf("pkt_gap%0d", n), 64'(c - last_c), 64'd2);
          last_c = c;
          n++;
        end
        if (req_ready[1]) adv = 1'b1;
      end
      if (n < 4) fail_timeout("pkt_writes");
      @(negedge clk); req_valid = '0; req_last = '1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Bus-side scheduler that owns the slot interface of one UART core and shares its transmit path among `NUM_REQ` byte producers. After reset it programs the core's control register and then serves requesters round-robin. For each byte it polls the status register until the TX FIFO is not full, then writes the byte to the write register. It sits between the producers (debug console, log streamer, command responder) and the UART slot, replacing direct MMIO writes.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2–8.
- `CTRL_INIT`, 16'h8035: value written to the control register after reset. Default is 8 data bits, no parity, 1 stop bit, dvsr = 53 (115200 baud at 100 MHz, 16x oversampling).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a byte.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is the last of a packet. Used only with packet lock.
- `req_ready` out NUM_REQ: one-hot, one-cycle accept pulse.
- `cfg_load` in 1: pulse requesting a rewrite of the control register.
- `cfg_ctrl` in 16: control value written on a `cfg_load` request. Sampled in the cycle `cfg_load` is high.
- `grant` out NUM_REQ: one-hot current owner; 0 when idle.
- `busy` out 1: high in any state other than IDLE.
- `slot_cs` out 1: slot chip select.
- `slot_read` out 1: slot read strobe.
- `slot_write` out 1: slot write strobe.
- `slot_addr` out 5: slot register address (0 CTRL, 1 STATUS, 3 WR).
- `slot_wr_data` out 32: slot write data.
- `slot_rd_data` in 32: slot read data, combinational from the core. Bit 4 is tx_full.

## Operation
- FSM states: RST, INIT, IDLE, POLL, WRITE, CFG.
- Slot outputs are decoded from the state. They are 0 in RST and IDLE.
- **RST:** entered on reset. Goes to INIT on the first clock after reset is released.
- **INIT:** drives cs=1, write=1, addr=0, wr_data={16'h0, CTRL_INIT}. Goes to IDLE.
- **cfg_load:** a pulse sets `cfg_pend` and captures `cfg_ctrl` into `cfg_q`. A second pulse before service overwrites `cfg_q`; the last value wins.
- **IDLE, config pending:** if `cfg_pend`=1, go to CFG. Configuration takes priority over arbitration.
- **IDLE, arbitration:** else if any `req_valid` is high, select the first valid index at or after `rr_ptr`, with wrap-around. Register it into `grant` and go to POLL.
- **CFG:** drives cs=1, write=1, addr=0, wr_data={16'h0, cfg_q}. Clears `cfg_pend` and goes to IDLE.
- **POLL:** drives cs=1, read=1, addr=1.
  - At the clock edge, if `slot_rd_data[4]`=0, go to WRITE. Otherwise stay in POLL.
  - A full FIFO stalls indefinitely with the grant held.
- **WRITE:** drives cs=1, write=1, addr=3, wr_data={24'h0, req_data[g]}. Asserts `req_ready[g]`=1.
  - Sets `rr_ptr` = (g+1) mod NUM_REQ, clears `grant` and goes to IDLE.
- **Requester rules:** a requester must hold `req_valid` and `req_data` stable from assertion until it sees `req_ready`. Deasserting `req_valid` before `req_ready` is illegal.
- The scheduler never drives `slot_read` together with addr=2; it does not consume RX data.

## Timing
- **Reset values:** all outputs are 0, `busy`=1 (RST), `rr_ptr`=0, `cfg_pend`=0, `grant`=0.
- **Reset mid-operation:** any byte not yet in WRITE is dropped without `req_ready`. A pending cfg is discarded. The controller re-runs INIT.
- **Minimum latency:** `req_valid` rise (sampled in IDLE) to `req_ready` is 3 cycles (IDLE, POLL, WRITE).
- **Throughput:** sustained rate is 1 byte per 3 cycles without packet lock.
- **Fairness:** with all requesters continuously valid, the grant order is 0,1,…,NUM_REQ-1,0.
- **cfg_load during a transfer:** serviced at the next IDLE, after the current WRITE completes.
- **cfg_load and cfg_pend in the same cycle:** `cfg_q` takes the new value.

## Configuration
- Macro: `UART_TX_SCHED_PKT_LOCK_EN`.
- **Defined:** packet lock is enabled.
  - In WRITE, if `req_last[g]`=0, the next state is POLL with `grant` held; `rr_ptr` and `grant` are not updated.
  - Lock releases on the WRITE with `req_last[g]`=1, then proceeds as normal.
  - While locked, POLL also waits for `req_valid[g]`=1.
  - Sustained in-packet rate is 1 byte per 2 cycles.
  - `cfg_pend` waits until the lock releases.
- **Undefined:** `req_last` is ignored; every byte is arbitrated separately.

## Test plan
- **Reset then idle:** expect one write, addr=0, data 32'h0000_8035, on the second cycle after reset deasserts. After that, `busy`=0 and no slot activity.
- **Single byte:** req 2 sends 8'h41 with `slot_rd_data[4]`=0. Expect POLL, then WR addr=3 data 32'h41 and `req_ready`=4'b0100, 3 cycles after `req_valid`.
- **Full FIFO:** tx_full=1 for 10 cycles. Expect 10+ POLL reads with no write and `grant` stable. The write follows in the cycle after tx_full falls.
- **Round-robin:** all 4 requesters valid with bytes 8'h10–8'h13. Expect write order 10,11,12,13,10…, with `req_ready` rotating.
- **cfg_load during a transfer:** `cfg_load` with 16'h0a1b pulsed while in POLL. Expect the byte write first, then CTRL write 32'h0000_0a1b, before the next grant.
- **Packet lock (macro defined):** req 1 sends 3 bytes, last flag on the third, while req 0 is valid. Expect all 3 req 1 writes back to back at 2-cycle spacing, then req 0.
